// File: rtl/psum_addr_pkg.sv
// Shared types and constants for the psum address generator slice.
package psum_addr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int F_WIDTH_DEF    = 6;
  localparam int N_WIDTH_DEF    = 3;
  localparam int E_WIDTH_DEF    = 8;
  localparam int C_WIDTH_DEF    = 8;
  localparam int ADDR_WIDTH_DEF = 16;
  localparam int DEPTH_DEF      = 4;

  // Cycles from tuple acceptance to FIFO write.
  localparam int PIPE_LATENCY   = 2;

endpackage

// File: rtl/psum_address_generator_if.sv
// GLB psum request channel: valid/ready with a linear address payload.
interface psum_address_generator_if
  import psum_addr_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
  logic                  req_valid;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_ready;

  modport master (output req_valid, output req_addr, input req_ready);
  modport slave  (input req_valid, input req_addr, output req_ready);
endinterface

// File: rtl/psum_addr_fifo.sv
// First-word-fall-through FIFO for psum addresses; falling-edge, async active-high reset.
module psum_addr_fifo
  import psum_addr_pkg::*;
#(
  parameter int WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // A pop on the same edge frees the slot, so push-while-full is legal then.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(negedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/psum_address_generator.sv
// Converts psum index tuples into linear GLB addresses (2-stage pipe + FWFT FIFO).
// Optional bounds check against limit_addr enabled by `define PSUM_ADDR_BOUNDS_CHECK_EN.
module psum_address_generator
  import psum_addr_pkg::*;
#(
  parameter int F_WIDTH    = F_WIDTH_DEF,
  parameter int n_WIDTH    = N_WIDTH_DEF,
  parameter int e_WIDTH    = E_WIDTH_DEF,
  parameter int C_WIDTH    = C_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic                  in_done,
  input  logic [n_WIDTH-1:0]    psum_index,
  input  logic [C_WIDTH-1:0]    channel_index,
  input  logic [e_WIDTH-1:0]    row_index,
  input  logic [F_WIDTH-1:0]    col_index,
  input  logic [C_WIDTH-1:0]    C,
  input  logic [e_WIDTH-1:0]    E,
  input  logic [F_WIDTH-1:0]    F,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] limit_addr,
  output logic                  await,
  psum_address_generator_if.master req,
  output logic                  busy,
  output logic                  done,
  output logic                  addr_err
);
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int PEND_W = CNT_W + $clog2(PIPE_LATENCY + 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic                  take_start;
  logic                  accept;
  logic                  bp_full;
  logic [PEND_W-1:0]     pending;

  logic                  vld_p1_q;
  logic                  vld_p2_q;
  logic [ADDR_WIDTH-1:0] s1_p1_q;
  logic [e_WIDTH-1:0]    row_p1_q;
  logic [F_WIDTH-1:0]    col_p1_q;
  logic [ADDR_WIDTH-1:0] addr_p2_d;
  logic [ADDR_WIDTH-1:0] addr_p2_q;

  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_full;
  logic                  fifo_empty;

  // Everything already committed downstream must still fit in the FIFO.
  assign pending = PEND_W'(fifo_count) + PEND_W'(vld_p1_q) + PEND_W'(vld_p2_q);
  assign bp_full = fifo_full || (pending >= PEND_W'(DEPTH - 1));

  always_comb begin
    state_d    = state_q;
    await      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    take_start = 1'b0;
    unique case (state_q)
      IDLE: begin
        await = 1'b1;
        if (start) begin
          take_start = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        await  = bp_full;
        accept = in_valid && !bp_full;
        if (in_done) state_d = DRAIN;
      end
      DRAIN: begin
        busy  = 1'b1;
        await = bp_full;
        if (!vld_p1_q && !vld_p2_q && fifo_empty) state_d = DONE;
      end
      DONE: begin
        await   = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      base_q   <= '0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      if (take_start) base_q <= base_addr;
      vld_p1_q <= accept;
      vld_p2_q <= vld_p1_q;
    end
  end

  // Stage 1: psum_index*C + channel_index
  always_ff @(negedge clk) begin
    if (accept) begin
      s1_p1_q  <= ADDR_WIDTH'(psum_index) * ADDR_WIDTH'(C) + ADDR_WIDTH'(channel_index);
      row_p1_q <= row_index;
      col_p1_q <= col_index;
    end
  end

  // Stage 2: base + (s1*E + row)*F + col
  assign addr_p2_d = base_q
                   + (s1_p1_q * ADDR_WIDTH'(E) + ADDR_WIDTH'(row_p1_q)) * ADDR_WIDTH'(F)
                   + ADDR_WIDTH'(col_p1_q);

  always_ff @(negedge clk) begin
    if (vld_p1_q) addr_p2_q <= addr_p2_d;
  end

`ifdef PSUM_ADDR_BOUNDS_CHECK_EN
  logic addr_err_q;

  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      addr_err_q <= 1'b0;
    end else if (take_start) begin
      addr_err_q <= 1'b0;
    end else if (vld_p1_q && (addr_p2_d > limit_addr)) begin
      addr_err_q <= 1'b1;
    end
  end

  assign addr_err = addr_err_q;
`else
  logic unused_limit;

  assign unused_limit = ^limit_addr;
  assign addr_err     = 1'b0;
`endif

  // FIFO write: two edges after acceptance
  psum_addr_fifo #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (vld_p2_q),
    .wdata_i (addr_p2_q),
    .pop_i   (req.req_ready),
    .rdata_o (req.req_addr),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign req.req_valid = !fifo_empty;

endmodule
